// File: rtl/dcache_byte.sv
// dcache_byte: single-port 32-bit word memory with byte/halfword/word
// loads and stores, a self-clearing INIT phase after reset, and a
// one-cycle-latency response carrying load data or a misalignment fault.
module dcache_byte #(
    parameter int          ADDR_W   = 7,
    parameter logic [3:0]  STR_UOP  = 4'b1001,
    parameter logic [3:0]  LDR_UOP  = 4'b1010,
    parameter logic [3:0]  STRB_UOP = 4'b1011,
    parameter logic [3:0]  LDRB_UOP = 4'b1100,
    parameter logic [3:0]  STRH_UOP = 4'b1101,
    parameter logic [3:0]  LDRH_UOP = 4'b1110
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] addr,
    input  logic [3:0]        uop,
    input  logic [31:0]       data_in,
    output logic              resp_valid,
    output logic [31:0]       data_out,
    output logic              fault
);

    localparam int IDX_W = ADDR_W - 2;
    localparam int DEPTH = 2 ** IDX_W;

    typedef enum logic {
        INIT,
        RUN
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IDX_W-1:0]  r_clr_cnt;
    logic [31:0]       r_mem [DEPTH];

    logic              r_resp_valid;
    logic              r_fault;
    logic [31:0]       r_data_out;

    logic [IDX_W-1:0]  w_idx;
    logic [31:0]       w_word;
    logic              w_uop_ok;
    logic              w_is_load;
    logic              w_is_store;
    logic              w_mis;
    logic [3:0]        w_be;
    logic [31:0]       w_wdata;
    logic [31:0]       w_ldata;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic              w_acc;

    assign w_idx  = addr[ADDR_W-1:2];
    assign w_word = r_mem[w_idx];

    // State register
    always_ff @(posedge clock) begin
        if (reset) r_state <= INIT;
        else       r_state <= w_state_nxt;
    end

    // Next-state: leave INIT once the last word has been cleared
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            INIT:    if (&r_clr_cnt) w_state_nxt = RUN;
            RUN:     w_state_nxt = RUN;
            default: w_state_nxt = INIT;
        endcase
    end

    // FSM outputs
    always_comb begin
        req_ready = (r_state == RUN);
    end

    // INIT clear counter, one word per cycle
    always_ff @(posedge clock) begin
        if (reset)                r_clr_cnt <= '0;
        else if (r_state == INIT) r_clr_cnt <= r_clr_cnt + 1'b1;
    end

    // Micro-op decode: legality, direction, alignment, byte enables, store data
    always_comb begin
        w_uop_ok   = 1'b0;
        w_is_load  = 1'b0;
        w_is_store = 1'b0;
        w_mis      = 1'b0;
        w_be       = 4'b0000;
        w_wdata    = '0;
        case (uop)
            STR_UOP: begin
                w_uop_ok   = 1'b1;
                w_is_store = 1'b1;
                w_mis      = (addr[1:0] != 2'b00);
                w_be       = 4'b1111;
                w_wdata    = data_in;
            end
            LDR_UOP: begin
                w_uop_ok  = 1'b1;
                w_is_load = 1'b1;
                w_mis     = (addr[1:0] != 2'b00);
            end
            STRB_UOP: begin
                w_uop_ok   = 1'b1;
                w_is_store = 1'b1;
                w_be       = 4'b0001 << addr[1:0];
                w_wdata    = {4{data_in[7:0]}};
            end
            LDRB_UOP: begin
                w_uop_ok  = 1'b1;
                w_is_load = 1'b1;
            end
            STRH_UOP: begin
                w_uop_ok   = 1'b1;
                w_is_store = 1'b1;
                w_mis      = addr[0];
                w_be       = addr[1] ? 4'b1100 : 4'b0011;
                w_wdata    = {2{data_in[15:0]}};
            end
            LDRH_UOP: begin
                w_uop_ok  = 1'b1;
                w_is_load = 1'b1;
                w_mis     = addr[0];
            end
            default: ;
        endcase
    end

    // Load data extraction, zero-extended
    always_comb begin
        case (addr[1:0])
            2'b00:   w_byte = w_word[7:0];
            2'b01:   w_byte = w_word[15:8];
            2'b10:   w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
        w_half  = addr[1] ? w_word[31:16] : w_word[15:0];
        w_ldata = '0;
        if (uop == LDR_UOP)       w_ldata = w_word;
        else if (uop == LDRH_UOP) w_ldata = {16'h0000, w_half};
        else if (uop == LDRB_UOP) w_ldata = {24'h000000, w_byte};
    end

    assign w_acc = req_valid && req_ready && w_uop_ok;

    // Memory: cleared during INIT, lane-masked stores in RUN; reset blocks writes
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (r_state == INIT) begin
                r_mem[r_clr_cnt] <= '0;
            end else if (w_acc && w_is_store && !w_mis) begin
                for (int unsigned i = 0; i < 4; i++) begin
                    if (w_be[i]) r_mem[w_idx][8*i +: 8] <= w_wdata[8*i +: 8];
                end
            end
        end
    end

    // Response register: one-cycle strobe, data/fault zero unless qualified
    always_ff @(posedge clock) begin
        if (reset) begin
            r_resp_valid <= 1'b0;
            r_fault      <= 1'b0;
            r_data_out   <= '0;
        end else begin
            r_resp_valid <= w_acc;
            r_fault      <= w_acc && w_mis;
            r_data_out   <= (w_acc && w_is_load && !w_mis) ? w_ldata : '0;
        end
    end

    assign resp_valid = r_resp_valid;
    assign fault      = r_fault;
    assign data_out   = r_data_out;

endmodule

// File: doc/dcache_byte.md
DCACHE_BYTE -- requirements
Module: dcache_byte

Interface
REQ-001 Parameter ADDR_W, default 7, byte-address width; memory SHALL hold DEPTH = 2**(ADDR_W-2) 32-bit words.
REQ-002 Parameter STR_UOP, default 4'b1001, word store.
REQ-003 Parameter LDR_UOP, default 4'b1010, word load.
REQ-004 Parameter STRB_UOP, default 4'b1011, byte store.
REQ-005 Parameter LDRB_UOP, default 4'b1100, byte load, zero-extended.
REQ-006 Parameter STRH_UOP, default 4'b1101, halfword store.
REQ-007 Parameter LDRH_UOP, default 4'b1110, halfword load, zero-extended.
REQ-008 Port clock, input, 1, sole clock, all state on rising edge.
REQ-009 Port reset, input, 1, synchronous active-high reset.
REQ-010 Port req_valid, input, 1, request present.
REQ-011 Port req_ready, output, 1, block accepts a request this cycle.
REQ-012 Port addr, input, ADDR_W, byte address.
REQ-013 Port uop, input, 4, micro-op.
REQ-014 Port data_in, input, 32, store data; byte/halfword taken from low bits.
REQ-015 Port resp_valid, output, 1, one-cycle response strobe.
REQ-016 Port data_out, output, 32, load result; 0 when resp_valid low.
REQ-017 Port fault, output, 1, misaligned access; qualified by resp_valid.

Function
REQ-018 States: INIT, RUN; reset SHALL enter INIT with clear counter 0.
REQ-019 INIT: one word per cycle written to 0, counter 0..DEPTH-1; req_ready=0; after writing word DEPTH-1, next state RUN.
REQ-020 RUN: req_ready=1 every cycle; a request is accepted when req_valid && req_ready && uop is one of the six defined uops.
REQ-021 Undefined uop or req_valid=0: no memory change, no response.
REQ-022 Word index = addr[ADDR_W-1:2]; byte lane = addr[1:0]; halfword lane = addr[1].
REQ-023 Alignment: word needs addr[1:0]=00; halfword needs addr[0]=0; byte always aligned.
REQ-024 Aligned store accepted at edge N: only the addressed lanes SHALL update at edge N; other lanes unchanged.
REQ-025 Every accepted request SHALL give resp_valid=1 for exactly the cycle after acceptance (latency 1); back-to-back requests give back-to-back responses.
REQ-026 Load response: data_out = addressed word/halfword/byte, zero-extended to 32 bits; fault=0.
REQ-027 Store response: data_out=0, fault=0.
REQ-028 Misaligned request: no memory write, resp_valid=1, fault=1, data_out=0.
REQ-029 Load at cycle N+1 to an address stored at cycle N SHALL return the new data.
REQ-030 fault and data_out SHALL be 0 whenever resp_valid=0.

Reset
REQ-031 reset high at any edge, including mid-INIT or with a response pending: state=INIT, counter=0, resp_valid=0, fault=0, data_out=0, req_ready=0 next cycle; pending response dropped.
REQ-032 reset has priority over any request presented in the same cycle; that request SHALL NOT write memory.

Verification
REQ-033 Reset 1 cycle, release -> req_ready=0 for exactly 32 cycles (default ADDR_W), then 1; LDR addr 0x7C -> data_out=0x00000000.
REQ-034 STR addr 0x28 data 0x12345678, next cycle LDR 0x28 -> resp_valid each cycle; load data_out=0x12345678.
REQ-035 Word 0x14 = 0xAABBCCDD; STRB 0x15 data 0xEE; LDR 0x14 -> 0xAABBEEDD; LDRB 0x17 -> 0x000000AA; LDRH 0x16 -> 0x0000AABB.
REQ-036 STR 0x0A (misaligned), LDRH 0x03 -> both resp fault=1, data_out=0; LDR 0x08 unchanged.
REQ-037 uop 4'b0010 with req_valid=1 -> no resp_valid, data_out=0, memory unchanged.
REQ-038 Store 0xDEADBEEF at 0x00, assert reset 10 cycles into INIT -> counter restarts, full 32-cycle INIT, LDR 0x00 -> 0x00000000.
